// File: rtl/aq_cp0_lpmd_mc.sv
// CP0 low-power-mode controller: quiesce handshake, mode drive, wake settle.
// Ports: WFI request/mode/acks/wakes in; sync req, lpmd_b, clk_en, stall out.
module aq_cp0_lpmd_mc #(
    parameter int ACK_NUM = 3,
    parameter int TO_W    = 8,
    parameter int WDLY_W  = 4
) (
    input  logic              lpmd_clk,
    input  logic              cpurst_b,
    input  logic              lpmd_req,
    input  logic [1:0]        lpmd_mode,
    input  logic [ACK_NUM-1:0] unit_no_op,
    input  logic              wake_int,
    input  logic              wake_dbg,
    input  logic              dbgon,
    input  logic              flush,
    input  logic [TO_W-1:0]   cfg_ack_to,
    input  logic [WDLY_W-1:0] cfg_wake_dly,
    output logic              lpmd_sync_req,
    output logic [1:0]        lpmd_b,
    output logic              in_lpmd,
    output logic              clk_en,
    output logic              lpmd_stall,
    output logic              lpmd_cmplt,
    output logic              ack_to_err,
    output logic [1:0]        cur_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_LPMD = 2'b10,
        ST_WAKE = 2'b11
    } state_e;

    localparam logic [TO_W-1:0]   TO_ONE = TO_W'(1);
    localparam logic [WDLY_W-1:0] WD_ONE = WDLY_W'(1);

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [ACK_NUM-1:0]  ack_mask_q;
    logic [ACK_NUM-1:0]  ack_mask_d;
    logic [TO_W-1:0]     to_cnt_q;
    logic [WDLY_W-1:0]   wake_cnt_q;
    logic [1:0]          lpmd_b_q;
    logic                in_lpmd_q;
    logic                clk_en_q;
    logic                cmplt_q;
    logic                to_err_q;

    logic all_ack;
    logic to_hit;
    logic wake_any;
    logic wdly_hit;

    // Mode 11 is reserved and falls back to plain wait.
    function automatic logic [1:0] enc(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'b01:   r = 2'b01;
            2'b10:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Acks are sticky so a unit may drop no_op once it has reported.
    assign ack_mask_d = ack_mask_q | unit_no_op;
    assign all_ack    = &ack_mask_d;
    assign to_hit     = (cfg_ack_to != '0) &&
                        (to_cnt_q == cfg_ack_to - TO_ONE);
    assign wake_any   = wake_int | wake_dbg | dbgon;
    assign wdly_hit   = (wake_cnt_q == cfg_wake_dly);

    always_comb begin
        lpmd_stall    = 1'b1;
        lpmd_sync_req = 1'b0;
        if (state_q == ST_IDLE) begin
            lpmd_stall = lpmd_req;
        end
        if (state_q == ST_WAIT) begin
            lpmd_sync_req = 1'b1;
        end
    end

    always_ff @(posedge lpmd_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'b00;
            ack_mask_q <= '0;
            to_cnt_q   <= '0;
            wake_cnt_q <= '0;
            lpmd_b_q   <= 2'b11;
            in_lpmd_q  <= 1'b0;
            clk_en_q   <= 1'b1;
            cmplt_q    <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            cmplt_q  <= 1'b0;
            to_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lpmd_req && !dbgon) begin
                        state_q    <= ST_WAIT;
                        mode_q     <= lpmd_mode;
                        ack_mask_q <= '0;
                        to_cnt_q   <= '0;
                        wake_cnt_q <= '0;
                    end
                end
                ST_WAIT: begin
                    ack_mask_q <= ack_mask_d;
                    if (flush || dbgon) begin
                        state_q <= ST_IDLE;
                    end else if (all_ack) begin
                        // Entry wins over a timeout landing the same cycle.
                        state_q   <= ST_LPMD;
                        lpmd_b_q  <= enc(mode_q);
                        in_lpmd_q <= 1'b1;
                        clk_en_q  <= 1'b0;
                    end else if (to_hit) begin
                        state_q  <= ST_IDLE;
                        to_err_q <= 1'b1;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + TO_ONE;
                    end
                end
                ST_LPMD: begin
                    if (wake_any) begin
                        state_q   <= ST_WAKE;
                        lpmd_b_q  <= 2'b11;
                        in_lpmd_q <= 1'b0;
                        clk_en_q  <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    wake_cnt_q <= wake_cnt_q + WD_ONE;
                    if (wdly_hit) begin
                        state_q <= ST_IDLE;
                        cmplt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lpmd_b     = lpmd_b_q;
    assign in_lpmd    = in_lpmd_q;
    assign clk_en     = clk_en_q;
    assign lpmd_cmplt = cmplt_q;
    assign ack_to_err = to_err_q;
    assign cur_state  = state_q;

endmodule
